// File: rtl/vsetvl_unit_pkg.sv
// Shared constants for the vsetvl configuration engine: vtype layout, AVL modes, FSM encodings.
// The optional strip-mining feature in vsetvl_unit is enabled by defining VSETVL_STRIPMINE_EN.
package vsetvl_unit_pkg;

    localparam int VLEN     = 64;
    localparam int AVL_W    = 7;
    localparam int VTYPE_W  = 7;
    localparam int VT_VALID = 6;
    localparam int VSEW_HI  = 5;
    localparam int VSEW_LO  = 3;
    localparam int VLMUL_HI = 2;
    localparam int VLMUL_LO = 0;

    localparam logic [1:0] MODE_AVL     = 2'b00;
    localparam logic [1:0] MODE_MAX     = 2'b01;
    localparam logic [1:0] MODE_KEEP    = 2'b10;
    localparam logic [1:0] MODE_AVL_ALT = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [VTYPE_W-1:0] VTYPE_ILLEGAL = 7'h7F;

    typedef struct packed {
        logic [AVL_W-1:0] vl;
        logic [AVL_W-1:0] avl;
        logic             illegal;
    } cfg_result_t;

    // Unsigned min of a 7-bit AVL against an 8-bit VLMAX; the result always fits in 7 bits.
    function automatic logic [AVL_W-1:0] umin_vl(input logic [AVL_W-1:0] a, input logic [7:0] vlmax);
        return ({1'b0, a} < vlmax) ? a : vlmax[AVL_W-1:0];
    endfunction

endpackage

// File: rtl/vsetvl_unit_vlmax_calc.sv
// Combinational VLMAX = (VLEN/8 >> vsew) << vlmul, flagging reserved vsew/vlmul encodings.
module vlmax_calc
    import vsetvl_unit_pkg::*;
(
    input  logic [2:0] vsew,
    input  logic [2:0] vlmul,
    output logic [7:0] vlmax,
    output logic       illegal
);

    localparam logic [7:0] BASE_ELEMS = 8'(VLEN / 8);

    always_comb begin
        illegal = (vsew > 3'd3) || (vlmul > 3'd3);
        vlmax   = 8'd0;
        if (!illegal) begin
            vlmax = (BASE_ELEMS >> vsew[1:0]) << vlmul[1:0];
        end
    end

endmodule

// File: rtl/vsetvl_unit.sv
// vsetvl/vsetvli engine: IDLE -> CALC -> COMMIT, producing {vl, AVL, vtype} for the vector register file.
// Define VSETVL_STRIPMINE_EN to enable strip-mining (strip_done re-commits with the remaining AVL).
module vsetvl_unit
    import vsetvl_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [AVL_W-1:0]   req_avl,
    input  logic [5:0]         req_vtypei,
    input  logic [1:0]         req_mode,
    input  logic [AVL_W-1:0]   cur_vl,
    output logic               rsp_valid,
    output logic [AVL_W-1:0]   rsp_vl,
    output logic [AVL_W-1:0]   vl_out,
    output logic [AVL_W-1:0]   AVL_out,
    output logic [VTYPE_W-1:0] vtype_out,
    input  logic               strip_done,
    output logic               strip_last
);

    logic [1:0]         state_q, state_d;
    logic [AVL_W-1:0]   avl_q, avl_d;
    logic [5:0]         vtypei_q, vtypei_d;
    logic [1:0]         mode_q, mode_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [AVL_W-1:0]   vl_q, vl_d;
    logic [AVL_W-1:0]   avl_out_q, avl_out_d;
    logic [VTYPE_W-1:0] vtype_out_q, vtype_out_d;

    logic [7:0]         vlmax_w;
    logic               vtype_illegal_w;
    logic [AVL_W-1:0]   avl_sel;
    cfg_result_t        res_w;

`ifdef VSETVL_STRIPMINE_EN
    logic               strip_active_q, strip_active_d;
    logic               pend_q, pend_d;
    logic [AVL_W-1:0]   strip_avl_q, strip_avl_d;
    logic [AVL_W-1:0]   strip_vl_q, strip_vl_d;
    logic [5:0]         strip_vtypei_q, strip_vtypei_d;
    logic               strip_last_q, strip_last_d;
    logic [AVL_W-1:0]   strip_rem;
`endif

    vlmax_calc u_vlmax_calc (
        .vsew    (vtypei_q[VSEW_HI:VSEW_LO]),
        .vlmul   (vtypei_q[VLMUL_HI:VLMUL_LO]),
        .vlmax   (vlmax_w),
        .illegal (vtype_illegal_w)
    );

    // Result of the configuration being evaluated in CALC; registered into the outputs on leaving CALC.
    always_comb begin
        case (mode_q)
            MODE_MAX:  avl_sel = vlmax_w[AVL_W-1:0];
            MODE_KEEP: avl_sel = cur_vl;
            default:   avl_sel = avl_q;
        endcase
        res_w.illegal = vtype_illegal_w || ((mode_q == MODE_KEEP) && ({1'b0, cur_vl} > vlmax_w));
        res_w.avl     = res_w.illegal ? '0 : avl_sel;
        res_w.vl      = res_w.illegal ? '0 : umin_vl(avl_sel, vlmax_w);
    end

    always_comb begin
        state_d     = state_q;
        avl_d       = avl_q;
        vtypei_d    = vtypei_q;
        mode_d      = mode_q;
        rsp_valid_d = 1'b0;
        vl_d        = vl_q;
        avl_out_d   = avl_out_q;
        vtype_out_d = {1'b0, vtype_out_q[VTYPE_W-2:0]};
`ifdef VSETVL_STRIPMINE_EN
        strip_active_d = strip_active_q;
        pend_d         = pend_q;
        strip_avl_d    = strip_avl_q;
        strip_vl_d     = strip_vl_q;
        strip_vtypei_d = strip_vtypei_q;
        strip_last_d   = 1'b0;
        strip_rem      = strip_avl_q - strip_vl_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    avl_d    = req_avl;
                    vtypei_d = req_vtypei;
                    mode_d   = req_mode;
                    state_d  = ST_CALC;
`ifdef VSETVL_STRIPMINE_EN
                    pend_d         = 1'b0;
                    strip_active_d = 1'b0;
`endif
                end
`ifdef VSETVL_STRIPMINE_EN
                else if (strip_active_q && (strip_done || pend_q)) begin
                    pend_d = 1'b0;
                    if (strip_rem == '0) begin
                        strip_last_d   = 1'b1;
                        strip_active_d = 1'b0;
                    end else begin
                        avl_d    = strip_rem;
                        vtypei_d = strip_vtypei_q;
                        mode_d   = MODE_AVL;
                        state_d  = ST_CALC;
                    end
                end else begin
                    pend_d = 1'b0;
                end
`endif
            end
            ST_CALC: begin
                state_d     = ST_COMMIT;
                rsp_valid_d = 1'b1;
                vl_d        = res_w.vl;
                avl_out_d   = res_w.avl;
                vtype_out_d = res_w.illegal ? VTYPE_ILLEGAL : {1'b1, vtypei_q};
`ifdef VSETVL_STRIPMINE_EN
                if (strip_done) pend_d = 1'b1;
                // Only an explicit-AVL commit starts or continues a strip sequence.
                if (!res_w.illegal && ((mode_q == MODE_AVL) || (mode_q == MODE_AVL_ALT))) begin
                    strip_active_d = 1'b1;
                    strip_avl_d    = res_w.avl;
                    strip_vl_d     = res_w.vl;
                    strip_vtypei_d = vtypei_q;
                end else begin
                    strip_active_d = 1'b0;
                end
`endif
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
`ifdef VSETVL_STRIPMINE_EN
                if (strip_done) pend_d = 1'b1;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            avl_q       <= '0;
            vtypei_q    <= '0;
            mode_q      <= '0;
            rsp_valid_q <= 1'b0;
            vl_q        <= '0;
            avl_out_q   <= '0;
            vtype_out_q <= '0;
        end else begin
            state_q     <= state_d;
            avl_q       <= avl_d;
            vtypei_q    <= vtypei_d;
            mode_q      <= mode_d;
            rsp_valid_q <= rsp_valid_d;
            vl_q        <= vl_d;
            avl_out_q   <= avl_out_d;
            vtype_out_q <= vtype_out_d;
        end
    end

`ifdef VSETVL_STRIPMINE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strip_active_q <= 1'b0;
            pend_q         <= 1'b0;
            strip_avl_q    <= '0;
            strip_vl_q     <= '0;
            strip_vtypei_q <= '0;
            strip_last_q   <= 1'b0;
        end else begin
            strip_active_q <= strip_active_d;
            pend_q         <= pend_d;
            strip_avl_q    <= strip_avl_d;
            strip_vl_q     <= strip_vl_d;
            strip_vtypei_q <= strip_vtypei_d;
            strip_last_q   <= strip_last_d;
        end
    end

    assign strip_last = strip_last_q;
`else
    logic unused_strip_done;
    assign unused_strip_done = strip_done;
    assign strip_last        = 1'b0;
`endif

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_vl    = vl_q;
    assign vl_out    = vl_q;
    assign AVL_out   = avl_out_q;
    assign vtype_out = vtype_out_q;

endmodule

// File: tb/tb_vsetvl_unit.sv
// Self-checking bench for vsetvl_unit: directed table, randomized model-checked requests, reset abort,
// and the strip-mining sequence when VSETVL_STRIPMINE_EN is defined.
module tb_vsetvl_unit;

    localparam int VLEN_TB = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_avl;
    logic [5:0] req_vtypei;
    logic [1:0] req_mode;
    logic [6:0] cur_vl;
    logic       rsp_valid;
    logic [6:0] rsp_vl;
    logic [6:0] vl_out;
    logic [6:0] AVL_out;
    logic [6:0] vtype_out;
    logic       strip_done;
    logic       strip_last;

    int n_vec  = 0;
    int n_miss = 0;

    vsetvl_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_avl    (req_avl),
        .req_vtypei (req_vtypei),
        .req_mode   (req_mode),
        .cur_vl     (cur_vl),
        .rsp_valid  (rsp_valid),
        .rsp_vl     (rsp_vl),
        .vl_out     (vl_out),
        .AVL_out    (AVL_out),
        .vtype_out  (vtype_out),
        .strip_done (strip_done),
        .strip_last (strip_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] avl;
        logic [5:0] vt;
        logic [1:0] mode;
        logic [6:0] cvl;
        logic [6:0] e_vl;
        logic [6:0] e_avl;
        logic [6:0] e_vt;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: VLMAX = (VLEN/SEW)*LMUL with SEW=8<<vsew, LMUL=1<<vlmul; vl = min(AVL, VLMAX).
    task automatic ref_model(input logic [6:0] avl, input logic [5:0] vt, input logic [1:0] mode,
                             input logic [6:0] cvl, output logic [6:0] vl, output logic [6:0] av,
                             output logic [6:0] vto);
        int sew_e, lm, vlmax, a;
        bit bad;
        sew_e = int'(vt[5:3]);
        lm    = int'(vt[2:0]);
        bad   = (sew_e > 3) || (lm > 3);
        vlmax = bad ? 0 : (VLEN_TB / (8 << sew_e)) * (1 << lm);
        case (mode)
            2'b01:   a = vlmax;
            2'b10: begin
                a = int'(cvl);
                if (a > vlmax) bad = 1'b1;
            end
            default: a = int'(avl);
        endcase
        if (bad) begin
            vl = 7'd0; av = 7'd0; vto = 7'h7F;
        end else begin
            vl = 7'((a < vlmax) ? a : vlmax);
            av = 7'(a);
            vto = {1'b1, vt};
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", int'(req_ready), 1);
    endtask

    task automatic do_req(input string tag, input logic [6:0] avl, input logic [5:0] vt,
                          input logic [1:0] mode, input logic [6:0] cvl, input logic [6:0] e_vl,
                          input logic [6:0] e_avl, input logic [6:0] e_vt);
        wait_ready();
        req_valid  = 1'b1;
        req_avl    = avl;
        req_vtypei = vt;
        req_mode   = mode;
        cur_vl     = cvl;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_calc_ready"}, int'(req_ready), 0);
        check({tag, "_calc_rsp"}, int'(rsp_valid), 0);
        @(negedge clk);
        check({tag, "_rsp_valid"}, int'(rsp_valid), 1);
        check({tag, "_rsp_vl"}, int'(rsp_vl), int'(e_vl));
        check({tag, "_vl_out"}, int'(vl_out), int'(e_vl));
        check({tag, "_avl_out"}, int'(AVL_out), int'(e_avl));
        check({tag, "_vtype"}, int'(vtype_out), int'(e_vt));
        check({tag, "_commit_ready"}, int'(req_ready), 0);
        $display("req %s avl=%0d vt=%02h mode=%0d cvl=%0d -> vl=%0d avl=%0d vtype=%02h", tag, avl, vt,
                 mode, cvl, rsp_vl, AVL_out, vtype_out);
        @(negedge clk);
        check({tag, "_post_rsp"}, int'(rsp_valid), 0);
        check({tag, "_post_vt6"}, int'(vtype_out[6]), 0);
        check({tag, "_post_hold"}, int'(vl_out), int'(e_vl));
    endtask

`ifdef VSETVL_STRIPMINE_EN
    // Waits (bounded) for the commit of a strip continuation and checks it.
    task automatic expect_commit(input string tag, input logic [6:0] e_vl, input logic [6:0] e_avl);
        int k = 0;
        while (!rsp_valid && k < 6) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_rsp_valid"}, int'(rsp_valid), 1);
        check({tag, "_vl"}, int'(rsp_vl), int'(e_vl));
        check({tag, "_avl"}, int'(AVL_out), int'(e_avl));
        check({tag, "_vtype"}, int'(vtype_out), 7'h40);
        $display("strip %s -> vl=%0d avl=%0d vtype=%02h", tag, rsp_vl, AVL_out, vtype_out);
        @(negedge clk);
    endtask
`endif

    initial begin
        logic [6:0] r_avl, r_cvl, e_vl, e_avl, e_vt;
        logic [5:0] r_vt;
        logic [1:0] r_mode;

        tbl[0] = '{7'd20,  6'b000000, 2'b00, 7'd0,  7'd8,  7'd20,  7'h40};
        tbl[1] = '{7'd5,   6'b001001, 2'b00, 7'd0,  7'd5,  7'd5,   7'h49};
        tbl[2] = '{7'd3,   6'b000011, 2'b01, 7'd0,  7'd64, 7'd64,  7'h43};
        tbl[3] = '{7'd0,   6'b011000, 2'b10, 7'd64, 7'd0,  7'd0,   7'h7F};
        tbl[4] = '{7'd10,  6'b100000, 2'b00, 7'd0,  7'd0,  7'd0,   7'h7F};
        tbl[5] = '{7'd100, 6'b000011, 2'b11, 7'd0,  7'd64, 7'd100, 7'h43};
        tbl[6] = '{7'd0,   6'b001000, 2'b10, 7'd3,  7'd3,  7'd3,   7'h48};
        tbl[7] = '{7'd9,   6'b000100, 2'b00, 7'd0,  7'd0,  7'd0,   7'h7F};
        tbl[8] = '{7'd0,   6'b010010, 2'b00, 7'd0,  7'd0,  7'd0,   7'h52};

        rst = 1'b1; req_valid = 1'b0; req_avl = '0; req_vtypei = '0; req_mode = '0;
        cur_vl = '0; strip_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", int'(req_ready), 0);
        check("reset_rsp", int'(rsp_valid), 0);
        check("reset_vl", int'(vl_out), 0);
        check("reset_avl", int'(AVL_out), 0);
        check("reset_vtype", int'(vtype_out), 0);
        check("reset_strip_last", int'(strip_last), 0);
        rst = 1'b0;
        #1;
        check("post_reset_ready", int'(req_ready), 1);

        for (int i = 0; i < 9; i++) begin
            do_req($sformatf("tbl%0d", i), tbl[i].avl, tbl[i].vt, tbl[i].mode, tbl[i].cvl,
                   tbl[i].e_vl, tbl[i].e_avl, tbl[i].e_vt);
        end

        for (int i = 0; i < 40; i++) begin
            r_avl  = 7'($urandom_range(0, 127));
            r_vt   = 6'($urandom);
            r_mode = 2'($urandom);
            r_cvl  = 7'($urandom_range(0, 70));
            ref_model(r_avl, r_vt, r_mode, r_cvl, e_vl, e_avl, e_vt);
            do_req($sformatf("rnd%0d", i), r_avl, r_vt, r_mode, r_cvl, e_vl, e_avl, e_vt);
        end

        // Reset during CALC aborts the request and zeroes all outputs immediately.
        do_req("pre_abort", 7'd20, 6'b000000, 2'b00, 7'd0, 7'd8, 7'd20, 7'h40);
        wait_ready();
        req_valid = 1'b1; req_avl = 7'd30; req_vtypei = 6'b000001; req_mode = 2'b00;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_vl", int'(vl_out), 0);
        check("abort_avl", int'(AVL_out), 0);
        check("abort_vtype", int'(vtype_out), 0);
        check("abort_rsp", int'(rsp_valid), 0);
        check("abort_ready", int'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("abort_no_rsp", int'(rsp_valid), 0);
            check("abort_ready_back", int'(req_ready), 1);
            @(negedge clk);
        end
        do_req("after_abort", 7'd30, 6'b000001, 2'b00, 7'd0, 7'd16, 7'd30, 7'h41);

`ifdef VSETVL_STRIPMINE_EN
        do_req("strip_start", 7'd20, 6'b000000, 2'b00, 7'd0, 7'd8, 7'd20, 7'h40);
        strip_done = 1'b1;
        @(negedge clk);
        strip_done = 1'b0;
        expect_commit("strip1", 7'd8, 7'd12);
        strip_done = 1'b1;
        @(negedge clk);
        strip_done = 1'b0;
        expect_commit("strip2", 7'd4, 7'd4);
        strip_done = 1'b1;
        @(negedge clk);
        strip_done = 1'b0;
        check("strip_last_pulse", int'(strip_last), 1);
        check("strip_last_no_rsp", int'(rsp_valid), 0);
        @(negedge clk);
        check("strip_last_clear", int'(strip_last), 0);
        check("strip_last_no_rsp2", int'(rsp_valid), 0);
        $display("strip final -> strip_last pulse observed=%0d", n_miss == 0);

        // strip_done arriving during CALC is held pending and serviced back in IDLE.
        wait_ready();
        req_valid = 1'b1; req_avl = 7'd10; req_vtypei = 6'b000000; req_mode = 2'b00;
        @(negedge clk);
        req_valid  = 1'b0;
        strip_done = 1'b1;
        @(negedge clk);
        strip_done = 1'b0;
        check("pend_first_vl", int'(rsp_vl), 8);
        check("pend_first_avl", int'(AVL_out), 10);
        @(negedge clk);
        expect_commit("pend_resume", 7'd2, 7'd2);
`else
        strip_done = 1'b1;
        @(negedge clk);
        strip_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("nostrip_rsp", int'(rsp_valid), 0);
            check("nostrip_last", int'(strip_last), 0);
            @(negedge clk);
        end
        $display("strip_done ignored in default build");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
